// File: rtl/seq_pkg.sv
// ============================================================================
//  seq_pkg : shared types and constants for the sequence hit counter
//  Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package seq_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX   = 4'd9;
  localparam int   STRETCH_W = 8;

endpackage : seq_pkg

`default_nettype wire

// File: rtl/bcd_digit.sv
// ============================================================================
//  bcd_digit : one decade counter 0..9 with carry out on the 9->0 wrap
//  Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module bcd_digit
  import seq_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic       inc,
  input  logic       clear,
  output logic [3:0] digit,
  output logic       carry
);

  assign carry = inc && (digit == BCD_MAX);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      digit <= '0;
    end else if (clear) begin
      digit <= '0;
    end else if (inc) begin
      digit <= carry ? 4'd0 : digit + 4'd1;
    end
  end

endmodule : bcd_digit

`default_nettype wire

// File: rtl/seq_hit_counter.sv
// ============================================================================
//  seq_hit_counter : 2-digit BCD hit counter with sticky overflow and a
//  retriggerable LED stretcher. Define SEQ_HIT_SAT_EN to saturate at 99.
//  Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module seq_hit_counter
  import seq_pkg::*;
#(
  parameter int STRETCH = 8
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       hit,
  input  logic       en,
  input  logic       zero,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic       ovf,
  output logic       hit_led
);

  localparam logic [STRETCH_W-1:0] STRETCH_LOAD = STRETCH_W'(STRETCH);

  logic                 hit_r;
  logic                 zero_r;
  logic [STRETCH_W-1:0] stretch_cnt;
  logic                 hit_req;
  logic                 at_max;
  logic                 inc;
  logic                 ones_carry;
  logic                 tens_carry;
  logic                 ovf_set;

  // A hit sampled on the same edge as zero lands in hit_r one cycle later;
  // zero_r drops it so the clear is not immediately undone.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      hit_r  <= 1'b0;
      zero_r <= 1'b0;
    end else begin
      hit_r  <= hit;
      zero_r <= zero;
    end
  end

  assign hit_req = hit_r & en & ~zero_r;
  assign at_max  = (ones == BCD_MAX) && (tens == BCD_MAX);

`ifdef SEQ_HIT_SAT_EN
  assign inc = hit_req & ~at_max;
`else
  assign inc = hit_req;
`endif

  bcd_digit u_ones (
    .clk   (clk),
    .clr   (clr),
    .inc   (inc),
    .clear (zero),
    .digit (ones),
    .carry (ones_carry)
  );

  bcd_digit u_tens (
    .clk   (clk),
    .clr   (clr),
    .inc   (ones_carry),
    .clear (zero),
    .digit (tens),
    .carry (tens_carry)
  );

  // Wrap raises tens_carry; saturation blocks it, so also flag the attempt.
  assign ovf_set = tens_carry | (hit_req & at_max);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      ovf <= 1'b0;
    end else if (zero) begin
      ovf <= 1'b0;
    end else if (ovf_set) begin
      ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      stretch_cnt <= '0;
    end else if (hit_r) begin
      stretch_cnt <= STRETCH_LOAD;
    end else if (stretch_cnt != '0) begin
      stretch_cnt <= stretch_cnt - 1'b1;
    end
  end

  assign hit_led = (stretch_cnt != '0);

endmodule : seq_hit_counter

`default_nettype wire

// File: tb/tb_seq_hit_counter.sv
// ============================================================================
//  tb_seq_hit_counter : directed scoreboard bench for seq_hit_counter
//  Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_seq_hit_counter;

  localparam int STRETCH = 8;
`ifdef SEQ_HIT_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       clr;
  logic       hit;
  logic       en;
  logic       zero;
  logic [3:0] ones;
  logic [3:0] tens;
  logic       ovf;
  logic       hit_led;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int m_cnt;
  int m_str;
  bit m_ovf;
  bit m_hit_r;
  bit m_zero_r;

  logic [9:0] exp_q[$];

  always #5 clk = ~clk;

  seq_hit_counter #(.STRETCH(STRETCH)) dut (
    .clk     (clk),
    .clr     (clr),
    .hit     (hit),
    .en      (en),
    .zero    (zero),
    .ones    (ones),
    .tens    (tens),
    .ovf     (ovf),
    .hit_led (hit_led)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [9:0] model_out();
    logic [3:0] t;
    logic [3:0] o;
    t = 4'(m_cnt / 10);
    o = 4'(m_cnt % 10);
    return {t, o, m_ovf, (m_str != 0)};
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_str = 0; m_ovf = 0; m_hit_r = 0; m_zero_r = 0;
    exp_q.delete();
  endtask

  // Drive one cycle at negedge, predict the state after the next edge,
  // then compare at the following negedge.
  task automatic step(input logic h, input logic e, input logic z, input string tag);
    logic [9:0] expv;
    if (z) begin
      m_cnt = 0;
      m_ovf = 0;
    end else if (m_hit_r && e && !m_zero_r) begin
      if (m_cnt == 99) begin
        m_ovf = 1;
        m_cnt = SAT ? 99 : 0;
      end else begin
        m_cnt++;
      end
    end
    m_str    = m_hit_r ? STRETCH : (m_str != 0 ? m_str - 1 : 0);
    m_hit_r  = h;
    m_zero_r = z;
    exp_q.push_back(model_out());
    hit  = h;
    en   = e;
    zero = z;
    @(posedge clk);
    @(negedge clk);
    expv = exp_q.pop_front();
    check(tag, {22'd0, tens, ones, ovf, hit_led}, {22'd0, expv});
  endtask

  task automatic idle(input int n, input logic e, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, e, 1'b0, tag);
  endtask

  initial begin
    int cnt_led;
    clr = 1'b0; hit = 1'b0; en = 1'b0; zero = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_outputs", {22'd0, tens, ones, ovf, hit_led}, 32'd0);
    clr = 1'b1;

    // Three isolated hits, each visible exactly two edges after sampling
    for (int k = 1; k <= 3; k++) begin
      step(1'b1, 1'b1, 1'b0, "iso_hit_edge1");
      check("iso_latency_edge1", {28'd0, ones}, 32'(k - 1));
      step(1'b0, 1'b1, 1'b0, "iso_hit_edge2");
      check("iso_latency_edge2", {28'd0, ones}, 32'(k));
      idle(2, 1'b1, "iso_gap");
    end
    check("iso_final", {23'd0, tens, ones, ovf}, {23'd0, 4'd0, 4'd3, 1'b0});

    // Held hit counts every cycle; LED lasts STRETCH cycles after hit_r falls
    step(1'b0, 1'b1, 1'b1, "clear_a");
    idle(10, 1'b1, "settle_a");
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0, "held_hit");
    step(1'b0, 1'b1, 1'b0, "held_tail");
    check("held_count12", {24'd0, tens, ones}, {24'd0, 4'd1, 4'd2});
    cnt_led = 0;
    for (int i = 0; i < 20 && hit_led; i++) begin
      step(1'b0, 1'b1, 1'b0, "held_stretch");
      if (hit_led) cnt_led++;
    end
    check("held_led_len", 32'(cnt_led), 32'(STRETCH - 1));
    check("held_led_off", {31'd0, hit_led}, 32'd0);

    // Zero coincident with hit at count 05
    step(1'b0, 1'b1, 1'b1, "clear_b");
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 1'b0, "to_five");
      step(1'b0, 1'b1, 1'b0, "to_five_gap");
    end
    check("at_five", {24'd0, tens, ones}, {24'd0, 4'd0, 4'd5});
    step(1'b1, 1'b1, 1'b1, "zero_with_hit");
    idle(3, 1'b1, "zero_after");
    check("zero_drop", {23'd0, tens, ones, ovf}, 32'd0);
    idle(8, 1'b1, "settle_b");

    // en=0: count holds, LED still follows hits; then retrigger
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, "pre_en");
    idle(10, 1'b1, "settle_c");
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b0, "en0_hit");
      step(1'b0, 1'b0, 1'b0, "en0_gap");
      check("en0_led", {31'd0, hit_led}, 32'd1);
      idle(10, 1'b0, "en0_wait");
    end
    check("en0_hold", {24'd0, tens, ones}, {24'd0, 4'd0, 4'd3});
    step(1'b1, 1'b0, 1'b0, "rt_first");
    step(1'b0, 1'b0, 1'b0, "rt_load");
    idle(3, 1'b0, "rt_mid");
    step(1'b1, 1'b0, 1'b0, "rt_second");
    step(1'b0, 1'b0, 1'b0, "rt_reload");
    cnt_led = 0;
    for (int i = 0; i < 20 && hit_led; i++) begin
      step(1'b0, 1'b0, 1'b0, "rt_stretch");
      if (hit_led) cnt_led++;
    end
    check("retrigger_len", 32'(cnt_led), 32'(STRETCH - 1));

    // 100 hits: wrap or saturate, then zero pulse
    step(1'b0, 1'b1, 1'b1, "clear_c");
    for (int i = 0; i < 100; i++) step(1'b1, 1'b1, 1'b0, "hundred");
    step(1'b0, 1'b1, 1'b0, "hundred_tail");
    if (SAT) check("hundred_sat", {23'd0, tens, ones, ovf}, {23'd0, 4'd9, 4'd9, 1'b1});
    else     check("hundred_wrap", {23'd0, tens, ones, ovf}, {23'd0, 4'd0, 4'd0, 1'b1});
    idle(2, 1'b1, "ovf_sticky");
    check("ovf_sticky", {31'd0, ovf}, 32'd1);
    step(1'b0, 1'b1, 1'b1, "zero_pulse");
    check("zero_clears_ovf", {23'd0, tens, ones, ovf}, 32'd0);
    idle(10, 1'b1, "settle_d");

    // Async reset at 37 mid-stretch, between clock edges
    for (int i = 0; i < 37; i++) step(1'b1, 1'b1, 1'b0, "to_37");
    step(1'b0, 1'b1, 1'b0, "to_37_tail");
    check("at_37", {23'd0, tens, ones, hit_led}, {23'd0, 4'd3, 4'd7, 1'b1});
    #2 clr = 1'b0;
    #1 check("async_reset", {22'd0, tens, ones, ovf, hit_led}, 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    check("reset_held", {22'd0, tens, ones, ovf, hit_led}, 32'd0);
    clr = 1'b1;
    idle(3, 1'b1, "post_reset");
    check("post_reset_zero", {22'd0, tens, ones, ovf, hit_led}, 32'd0);
    step(1'b1, 1'b1, 1'b0, "fresh_hit");
    step(1'b0, 1'b1, 1'b0, "fresh_count");
    check("fresh_count", {24'd0, tens, ones}, {24'd0, 4'd0, 4'd1});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_seq_hit_counter

`default_nettype wire
